// File: rtl/ulpi_pkg.sv
// Shared definitions for the PHY-side ULPI responder: TXCMD opcodes,
// register map and reset values, RxEvent encodings and the FSM state type.
package ulpi_pkg;

  // TXCMD opcode field, bits [7:6] of the command byte
  localparam logic [1:0] TXCMD_SPECIAL  = 2'b00;
  localparam logic [1:0] TXCMD_TRANSMIT = 2'b01;
  localparam logic [1:0] TXCMD_REGWR    = 2'b10;
  localparam logic [1:0] TXCMD_REGRD    = 2'b11;

  // Register base addresses; base+1 is the set alias, base+2 the clear alias
  localparam logic [5:0] ADDR_VID_LO    = 6'h00;
  localparam logic [5:0] ADDR_VID_HI    = 6'h01;
  localparam logic [5:0] ADDR_PID_LO    = 6'h02;
  localparam logic [5:0] ADDR_PID_HI    = 6'h03;
  localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
  localparam logic [5:0] ADDR_INTF_CTRL = 6'h07;
  localparam logic [5:0] ADDR_OTG_CTRL  = 6'h0A;
  localparam logic [5:0] ADDR_SCRATCH   = 6'h16;

  localparam logic [7:0] RST_FUNC_CTRL  = 8'h41;
  localparam logic [7:0] RST_INTF_CTRL  = 8'h00;
  localparam logic [7:0] RST_OTG_CTRL   = 8'h06;
  localparam logic [7:0] RST_SCRATCH    = 8'h00;

  localparam int FUNC_CTRL_RESET_BIT = 5;

  // RxEvent field, bits [5:4] of an RXCMD
  localparam logic [1:0] RXEV_IDLE   = 2'b00;
  localparam logic [1:0] RXEV_ACTIVE = 2'b01;
  localparam logic [1:0] RXEV_ERROR  = 2'b11;

  // 8-bit state encoding to line up with the link controller
  typedef enum logic [7:0] {
    ST_PHY_RST   = 8'h00,
    ST_RST_TA    = 8'h01,
    ST_IDLE      = 8'h02,
    ST_WR_CMD    = 8'h10,
    ST_WR_DATA   = 8'h11,
    ST_WR_STP    = 8'h12,
    ST_RD_CMD    = 8'h20,
    ST_RD_TA     = 8'h21,
    ST_RD_DATA   = 8'h22,
    ST_RD_END    = 8'h23,
    ST_TX_PID    = 8'h30,
    ST_TX_BODY   = 8'h31,
    ST_RX_TA     = 8'h40,
    ST_RX_CMD    = 8'h41,
    ST_RX_BYTE   = 8'h42,
    ST_RX_ERRCMD = 8'h43,
    ST_RX_EOP    = 8'h44,
    ST_RX_END    = 8'h45,
    ST_CMD_TA    = 8'h50,
    ST_CMD_OUT   = 8'h51,
    ST_CMD_END   = 8'h52
  } phy_state_e;

  function automatic logic [7:0] make_rxcmd(input logic [1:0] ls,
                                            input logic [1:0] vbus,
                                            input logic [1:0] ev);
    return {2'b00, ev, vbus, ls};
  endfunction

  // True when a falls on base or its set/clear aliases
  function automatic logic reg_hit(input logic [5:0] a, input logic [5:0] base);
    return (a == base) || (a == base + 6'd1) || (a == base + 6'd2);
  endfunction

  // Apply a write/set/clear access at address a to the register at base
  function automatic logic [7:0] reg_update(input logic [7:0] cur,
                                            input logic [5:0] base,
                                            input logic [5:0] a,
                                            input logic [7:0] d);
    if (a == base)             return d;
    else if (a == base + 6'd1) return cur | d;
    else if (a == base + 6'd2) return cur & ~d;
    return cur;
  endfunction

endpackage

// File: rtl/ulpi_phy_regs.sv
// Minimal ULPI register file: ID bytes, FUNC_CTRL/INTF_CTRL/OTG_CTRL/SCRATCH
// with write/set/clear aliases. A FUNC_CTRL access that would set the Reset
// bit is flagged on func_reset and the bit is never stored.
module ulpi_phy_regs
  import ulpi_pkg::*;
#(
  parameter logic [15:0] VID = 16'h0424,
  parameter logic [15:0] PID = 16'h0009
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic       wr_en,
  input  logic [5:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic [7:0] func_ctrl,
  output logic       func_reset
);

  logic [7:0] func_q, func_d, intf_q, intf_d, otg_q, otg_d, scratch_q, scratch_d;
  logic [7:0] func_upd;

  // Next register values for a committed access
  always_comb begin
    func_upd   = reg_update(func_q, ADDR_FUNC_CTRL, addr, wr_data);
    func_reset = wr_en && func_upd[FUNC_CTRL_RESET_BIT];
    func_d     = func_q;
    intf_d     = intf_q;
    otg_d      = otg_q;
    scratch_d  = scratch_q;
    if (wr_en) begin
      func_d                      = func_upd;
      func_d[FUNC_CTRL_RESET_BIT] = 1'b0;
      intf_d                      = reg_update(intf_q, ADDR_INTF_CTRL, addr, wr_data);
      otg_d                       = reg_update(otg_q, ADDR_OTG_CTRL, addr, wr_data);
      scratch_d                   = reg_update(scratch_q, ADDR_SCRATCH, addr, wr_data);
    end
  end

  // Register storage
  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      func_q    <= RST_FUNC_CTRL;
      intf_q    <= RST_INTF_CTRL;
      otg_q     <= RST_OTG_CTRL;
      scratch_q <= RST_SCRATCH;
    end else begin
      func_q    <= func_d;
      intf_q    <= intf_d;
      otg_q     <= otg_d;
      scratch_q <= scratch_d;
    end
  end

  // Read mux; set/clear aliases read back the underlying register
  always_comb begin
    rd_data = 8'h00;
    if (addr == ADDR_VID_LO)                 rd_data = VID[7:0];
    else if (addr == ADDR_VID_HI)            rd_data = VID[15:8];
    else if (addr == ADDR_PID_LO)            rd_data = PID[7:0];
    else if (addr == ADDR_PID_HI)            rd_data = PID[15:8];
    else if (reg_hit(addr, ADDR_FUNC_CTRL))  rd_data = func_q;
    else if (reg_hit(addr, ADDR_INTF_CTRL))  rd_data = intf_q;
    else if (reg_hit(addr, ADDR_OTG_CTRL))   rd_data = otg_q;
    else if (reg_hit(addr, ADDR_SCRATCH))    rd_data = scratch_q;
  end

  assign func_ctrl = func_q;

endmodule

// File: rtl/ulpi_phy_model.sv
// PHY-side ULPI responder: owns DIR/NXT, decodes TXCMDs, captures transmit
// packets and injects receive packets and RXCMDs.
// Build option: define ULPI_PHY_RX_ERR_EN to add the RX_ERR input, which
// ends an injected packet with an RxError RXCMD.
//
// state        | meaning
// PHY_RST      | DIR high for RESET_CYCLES after reset / FUNC_CTRL.Reset
// RST_TA       | DIR low turnaround out of reset
// IDLE         | bus owned by link; arbitrate TXCMD > RX inject > RXCMD
// WR_CMD       | NXT acknowledges register-write command
// WR_DATA      | NXT high, latch write data
// WR_STP       | wait for STP, then commit
// RD_CMD       | NXT acknowledges register-read command
// RD_TA        | DIR high turnaround
// RD_DATA      | register value on bus
// RD_END       | DIR low turnaround
// TX_PID       | NXT high, PID captured from command
// TX_BODY      | capture bytes until STP
// RX_TA        | DIR high turnaround for injection
// RX_CMD       | RXCMD with RxActive
// RX_BYTE      | data bytes with NXT, RXCMD on gaps
// RX_ERRCMD    | RXCMD with RxError
// RX_EOP       | RXCMD with RxEvent idle, records reported state
// RX_END       | DIR low turnaround
// CMD_TA       | DIR high turnaround for line-state report
// CMD_OUT      | RXCMD with line state, records reported state
// CMD_END      | DIR low turnaround
module ulpi_phy_model
  import ulpi_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 16,
  parameter logic [15:0] VID          = 16'h0424,
  parameter logic [15:0] PID          = 16'h0009
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_DIR,
  output logic       ULPI_NXT,
  input  logic       ULPI_STP,
  input  logic [1:0] LINESTATE,
  input  logic [1:0] VBUS,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  input  logic       RX_LAST,
  output logic       RX_READY,
  output logic [7:0] TX_DATA,
  output logic       TX_STRB,
  output logic       TX_END,
  output logic [7:0] REG_FUNC_CTRL,
  output logic       BUSY
`ifdef ULPI_PHY_RX_ERR_EN
  ,
  input  logic       RX_ERR
`endif
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_CYCLES - 1);

  phy_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [3:0] last_q, last_d;

  logic       reg_wr_en;
  logic       func_reset;
  logic [7:0] reg_rd_data;
  logic [3:0] ls_now;
  logic [7:0] rxcmd_idle, rxcmd_active;

  assign ls_now       = {VBUS, LINESTATE};
  assign rxcmd_idle   = make_rxcmd(LINESTATE, VBUS, RXEV_IDLE);
  assign rxcmd_active = make_rxcmd(LINESTATE, VBUS, RXEV_ACTIVE);

  ulpi_phy_regs #(
    .VID(VID),
    .PID(PID)
  ) u_regs (
    .CLK_60M    (CLK_60M),
    .NRST_A_USB (NRST_A_USB),
    .wr_en      (reg_wr_en),
    .addr       (addr_q),
    .wr_data    (wdata_q),
    .rd_data    (reg_rd_data),
    .func_ctrl  (REG_FUNC_CTRL),
    .func_reset (func_reset)
  );

  // State, reset timer and latched transaction fields
  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state_q <= ST_PHY_RST;
      cnt_q   <= CNT_LOAD;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  // Next-state and bus outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    last_d      = last_q;
    ULPI_DIR    = 1'b0;
    ULPI_NXT    = 1'b0;
    ULPI_DATA_O = 8'h00;
    RX_READY    = 1'b0;
    TX_DATA     = 8'h00;
    TX_STRB     = 1'b0;
    TX_END      = 1'b0;
    reg_wr_en   = 1'b0;

    unique case (state_q)
      ST_PHY_RST: begin
        ULPI_DIR = 1'b1;
        if (cnt_q == '0) state_d = ST_RST_TA;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RST_TA: state_d = ST_IDLE;
      ST_IDLE: begin
        if (ULPI_DATA_I != 8'h00) begin
          addr_d = ULPI_DATA_I[5:0];
          unique case (ULPI_DATA_I[7:6])
            TXCMD_REGWR:    state_d = ST_WR_CMD;
            TXCMD_REGRD:    state_d = ST_RD_CMD;
            TXCMD_TRANSMIT: state_d = ST_TX_PID;
            TXCMD_SPECIAL:  state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
          endcase
        end else if (RX_VALID) begin
          state_d = ST_RX_TA;
        end else if (ls_now != last_q) begin
          state_d = ST_CMD_TA;
        end
      end
      ST_WR_CMD: begin
        ULPI_NXT = 1'b1;
        state_d  = ULPI_STP ? ST_IDLE : ST_WR_DATA;
      end
      ST_WR_DATA: begin
        ULPI_NXT = 1'b1;
        if (ULPI_STP) begin
          state_d = ST_IDLE;
        end else begin
          wdata_d = ULPI_DATA_I;
          state_d = ST_WR_STP;
        end
      end
      ST_WR_STP: begin
        if (ULPI_STP) begin
          reg_wr_en = 1'b1;
          if (func_reset) begin
            state_d = ST_PHY_RST;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RD_CMD: begin
        ULPI_NXT = 1'b1;
        state_d  = ST_RD_TA;
      end
      ST_RD_TA: begin
        ULPI_DIR = 1'b1;
        state_d  = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        ULPI_DIR    = 1'b1;
        ULPI_DATA_O = reg_rd_data;
        state_d     = ST_RD_END;
      end
      ST_RD_END: state_d = ST_IDLE;
      ST_TX_PID: begin
        ULPI_NXT = 1'b1;
        if (ULPI_STP) begin
          state_d = ST_IDLE;
        end else begin
          TX_DATA = {4'b0000, addr_q[3:0]};
          TX_STRB = 1'b1;
          state_d = ST_TX_BODY;
        end
      end
      ST_TX_BODY: begin
        if (ULPI_STP) begin
          TX_END  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ULPI_NXT = 1'b1;
          TX_DATA  = ULPI_DATA_I;
          TX_STRB  = 1'b1;
        end
      end
      ST_RX_TA: begin
        ULPI_DIR = 1'b1;
        state_d  = ST_RX_CMD;
      end
      ST_RX_CMD: begin
        ULPI_DIR    = 1'b1;
        ULPI_DATA_O = rxcmd_active;
        state_d     = ST_RX_BYTE;
      end
      ST_RX_BYTE: begin
        ULPI_DIR = 1'b1;
        if (RX_VALID) begin
          ULPI_NXT    = 1'b1;
          ULPI_DATA_O = RX_DATA;
          RX_READY    = 1'b1;
          if (RX_LAST) state_d = ST_RX_EOP;
        end else begin
          ULPI_DATA_O = rxcmd_active;
        end
`ifdef ULPI_PHY_RX_ERR_EN
        if (RX_ERR) state_d = ST_RX_ERRCMD;
`endif
      end
      ST_RX_ERRCMD: begin
        ULPI_DIR    = 1'b1;
        ULPI_DATA_O = make_rxcmd(LINESTATE, VBUS, RXEV_ERROR);
        state_d     = ST_RX_EOP;
      end
      ST_RX_EOP: begin
        ULPI_DIR    = 1'b1;
        ULPI_DATA_O = rxcmd_idle;
        last_d      = ls_now;
        state_d     = ST_RX_END;
      end
      ST_RX_END: state_d = ST_IDLE;
      ST_CMD_TA: begin
        ULPI_DIR = 1'b1;
        state_d  = ST_CMD_OUT;
      end
      ST_CMD_OUT: begin
        ULPI_DIR    = 1'b1;
        ULPI_DATA_O = rxcmd_idle;
        last_d      = ls_now;
        state_d     = ST_CMD_END;
      end
      ST_CMD_END: state_d = ST_IDLE;
      default: state_d = ST_PHY_RST;
    endcase
  end

  assign BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ulpi_phy_model.sv
// Directed self-checking bench for ulpi_phy_model.
module tb_ulpi_phy_model;

  logic       CLK_60M = 1'b0;
  logic       NRST_A_USB = 1'b0;
  logic [7:0] ULPI_DATA_I = 8'h00;
  logic [7:0] ULPI_DATA_O;
  logic       ULPI_DIR, ULPI_NXT;
  logic       ULPI_STP = 1'b0;
  logic [1:0] LINESTATE = 2'b00;
  logic [1:0] VBUS = 2'b00;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_VALID = 1'b0;
  logic       RX_LAST = 1'b0;
  logic       RX_READY;
  logic [7:0] TX_DATA;
  logic       TX_STRB, TX_END;
  logic [7:0] REG_FUNC_CTRL;
  logic       BUSY;
`ifdef ULPI_PHY_RX_ERR_EN
  logic       RX_ERR = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [8:0] cap [16];
  int         cap_n;
  logic [8:0] exp_rx [8];

  ulpi_phy_model dut (
    .CLK_60M(CLK_60M), .NRST_A_USB(NRST_A_USB),
    .ULPI_DATA_I(ULPI_DATA_I), .ULPI_DATA_O(ULPI_DATA_O),
    .ULPI_DIR(ULPI_DIR), .ULPI_NXT(ULPI_NXT), .ULPI_STP(ULPI_STP),
    .LINESTATE(LINESTATE), .VBUS(VBUS),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_LAST(RX_LAST), .RX_READY(RX_READY),
    .TX_DATA(TX_DATA), .TX_STRB(TX_STRB), .TX_END(TX_END),
    .REG_FUNC_CTRL(REG_FUNC_CTRL), .BUSY(BUSY)
`ifdef ULPI_PHY_RX_ERR_EN
    , .RX_ERR(RX_ERR)
`endif
  );

  always #8 CLK_60M = ~CLK_60M;

  task automatic tick;
    @(posedge CLK_60M);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (BUSY && k < 64) begin
      tick();
      k++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_timeout busy=%0b expected 0", tag, BUSY);
    end
  endtask

  task automatic count_dir_high(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!ULPI_DIR) break;
      n++;
      tick();
    end
  endtask

  task automatic do_write(input logic [7:0] cmd, input logic [7:0] data, output logic nxt_ack);
    wait_idle("write");
    ULPI_DATA_I = cmd;
    tick();
    nxt_ack = ULPI_NXT;
    tick();
    ULPI_DATA_I = data;
    tick();
    ULPI_DATA_I = 8'h00;
    ULPI_STP = 1'b1;
    tick();
    ULPI_STP = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] addr, output logic [7:0] data, output logic dir_at_data);
    wait_idle("read");
    ULPI_DATA_I = {2'b11, addr};
    tick();
    tick();
    ULPI_DATA_I = 8'h00;
    tick();
    data = ULPI_DATA_O;
    dir_at_data = ULPI_DIR;
    tick();
  endtask

  task automatic rx_capture(input logic [7:0] b0, input logic [7:0] b1, input bit gap);
    int  idx;
    bit  hold, seen, ready;
    idx = 0; hold = 0; seen = 0;
    cap_n = 0;
    RX_DATA = b0; RX_LAST = 1'b0; RX_VALID = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK_60M);
      ready = RX_READY;
      if (ULPI_DIR) begin
        seen = 1;
        if (cap_n < 16) cap[cap_n] = {ULPI_NXT, ULPI_DATA_O};
        cap_n++;
      end else if (seen) begin
        break;
      end
      tick();
      if (hold) begin
        hold = 0; RX_VALID = 1'b1; RX_DATA = b1; RX_LAST = 1'b1;
      end else if (ready) begin
        idx++;
        if (idx == 1) begin
          if (gap) begin RX_VALID = 1'b0; hold = 1; end
          else begin RX_DATA = b1; RX_LAST = 1'b1; end
        end else begin
          RX_VALID = 1'b0; RX_LAST = 1'b0; RX_DATA = 8'h00;
        end
      end
    end
    RX_VALID = 1'b0; RX_LAST = 1'b0; RX_DATA = 8'h00;
    tick();
  endtask

  task automatic test_reset;
    int n;
    logic [7:0] rd;
    logic dd;
    repeat (3) @(posedge CLK_60M);
    #1;
    checks++;
    if ({ULPI_DIR, ULPI_NXT, ULPI_DATA_O, BUSY, TX_STRB, TX_END, RX_READY} !== {1'b1, 1'b0, 8'h00, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs dir=%0b nxt=%0b data=%h busy=%0b strb=%0b end=%0b ready=%0b expected 1 0 00 1 0 0 0",
               ULPI_DIR, ULPI_NXT, ULPI_DATA_O, BUSY, TX_STRB, TX_END, RX_READY);
    end
    checks++;
    if (REG_FUNC_CTRL !== 8'h41) begin
      errors++; $display("FAIL reset_func_ctrl got=%h expected 41", REG_FUNC_CTRL);
    end
    NRST_A_USB = 1'b1;
    count_dir_high(n);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL reset_dir_cycles got=%0d expected 16", n); end
    tick();
    checks++;
    if (ULPI_DIR !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_idle dir=%0b busy=%0b expected 0 0", ULPI_DIR, BUSY);
    end
    do_read(6'h04, rd, dd);
    checks++;
    if (rd !== 8'h41 || dd !== 1'b1) begin
      errors++; $display("FAIL read_func_ctrl got=%h dir=%0b expected 41 dir 1", rd, dd);
    end
  endtask

  task automatic test_regs;
    logic [7:0] rd;
    logic dd, ack;
    do_write(8'h96, 8'h5A, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL write_nxt_ack got=%0b expected 1", ack); end
    do_read(6'h16, rd, dd);
    checks++;
    if (rd !== 8'h5A) begin errors++; $display("FAIL scratch_write got=%h expected 5a", rd); end
    do_write(8'h97, 8'h0F, ack);
    do_read(6'h16, rd, dd);
    checks++;
    if (rd !== 8'h5F || dd !== 1'b1) begin
      errors++; $display("FAIL scratch_set got=%h dir=%0b expected 5f dir 1", rd, dd);
    end
    do_read(6'h00, rd, dd);
    checks++;
    if (rd !== 8'h24) begin errors++; $display("FAIL vid_lo got=%h expected 24", rd); end
    do_read(6'h01, rd, dd);
    checks++;
    if (rd !== 8'h04) begin errors++; $display("FAIL vid_hi got=%h expected 04", rd); end
    do_read(6'h02, rd, dd);
    checks++;
    if (rd !== 8'h09) begin errors++; $display("FAIL pid_lo got=%h expected 09", rd); end
    do_read(6'h0A, rd, dd);
    checks++;
    if (rd !== 8'h06) begin errors++; $display("FAIL otg_reset got=%h expected 06", rd); end
    do_write(8'hB0, 8'hFF, ack);
    do_read(6'h30, rd, dd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL unmapped_read got=%h expected 00", rd); end
  endtask

  task automatic test_write_abort;
    logic [7:0] rd;
    logic dd;
    wait_idle("abort");
    ULPI_DATA_I = 8'h96;
    tick();
    tick();
    ULPI_DATA_I = 8'h77;
    ULPI_STP = 1'b1;
    tick();
    ULPI_DATA_I = 8'h00;
    ULPI_STP = 1'b0;
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_to_idle busy=%0b expected 0", BUSY); end
    do_read(6'h16, rd, dd);
    checks++;
    if (rd !== 8'h5F) begin errors++; $display("FAIL abort_no_commit got=%h expected 5f", rd); end
  endtask

  task automatic test_func_reset;
    int n;
    logic ack;
    do_write(8'h84, 8'h61, ack);
    count_dir_high(n);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL func_reset_dir_cycles got=%0d expected 16", n); end
    checks++;
    if (REG_FUNC_CTRL !== 8'h41) begin
      errors++; $display("FAIL func_reset_selfclear got=%h expected 41", REG_FUNC_CTRL);
    end
    do_write(8'h86, 8'h40, ack);
    checks++;
    if (REG_FUNC_CTRL !== 8'h01 || BUSY !== 1'b0) begin
      errors++; $display("FAIL func_clear got=%h busy=%0b expected 01 busy 0", REG_FUNC_CTRL, BUSY);
    end
  endtask

  task automatic test_transmit;
    logic [7:0] got [8];
    int ns, ne;
    ns = 0; ne = 0;
    wait_idle("tx");
    ULPI_DATA_I = 8'h43;
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK_60M);
      if (TX_STRB) begin
        if (ns < 8) got[ns] = TX_DATA;
        ns++;
      end
      if (TX_END) ne++;
      tick();
      case (c)
        1: ULPI_DATA_I = 8'hAA;
        2: ULPI_DATA_I = 8'hBB;
        3: begin ULPI_DATA_I = 8'h00; ULPI_STP = 1'b1; end
        4: ULPI_STP = 1'b0;
        default: ;
      endcase
    end
    checks++;
    if (ns !== 3 || ne !== 1) begin
      errors++; $display("FAIL tx_counts strobes=%0d ends=%0d expected 3 1", ns, ne);
    end
    checks++;
    if (got[0] !== 8'h03 || got[1] !== 8'hAA || got[2] !== 8'hBB) begin
      errors++; $display("FAIL tx_bytes got=%h %h %h expected 03 aa bb", got[0], got[1], got[2]);
    end
  endtask

  task automatic test_tx_abort;
    int ns, ne;
    ns = 0; ne = 0;
    wait_idle("tx_abort");
    ULPI_DATA_I = 8'h45;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK_60M);
      if (TX_STRB) ns++;
      if (TX_END) ne++;
      tick();
      if (c == 0) begin ULPI_DATA_I = 8'h00; ULPI_STP = 1'b1; end
      if (c == 1) ULPI_STP = 1'b0;
    end
    checks++;
    if (ns !== 0 || ne !== 0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL tx_abort strobes=%0d ends=%0d busy=%0b expected 0 0 0", ns, ne, BUSY);
    end
  endtask

  task automatic test_rx_inject;
    wait_idle("rx");
    LINESTATE = 2'b01;
    ULPI_STP = 1'b1;
    rx_capture(8'h11, 8'h22, 1'b0);
    ULPI_STP = 1'b0;
    exp_rx[0] = 9'h000; exp_rx[1] = 9'h011; exp_rx[2] = 9'h111;
    exp_rx[3] = 9'h122; exp_rx[4] = 9'h001;
    checks++;
    if (cap_n !== 5) begin errors++; $display("FAIL rx_dir_cycles got=%0d expected 5", cap_n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap[i] !== exp_rx[i]) begin
        errors++; $display("FAIL rx_bus[%0d] got nxt,data=%h expected %h", i, cap[i], exp_rx[i]);
      end
    end
    checks++;
    if (ULPI_DIR !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL rx_back_idle dir=%0b busy=%0b expected 0 0", ULPI_DIR, BUSY);
    end
  endtask

  task automatic test_rx_gap;
    wait_idle("rx_gap");
    rx_capture(8'h33, 8'h44, 1'b1);
    exp_rx[0] = 9'h000; exp_rx[1] = 9'h011; exp_rx[2] = 9'h133;
    exp_rx[3] = 9'h011; exp_rx[4] = 9'h144; exp_rx[5] = 9'h001;
    checks++;
    if (cap_n !== 6) begin errors++; $display("FAIL rx_gap_cycles got=%0d expected 6", cap_n); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cap[i] !== exp_rx[i]) begin
        errors++; $display("FAIL rx_gap_bus[%0d] got nxt,data=%h expected %h", i, cap[i], exp_rx[i]);
      end
    end
  endtask

  task automatic test_arbitration;
    wait_idle("arb");
    ULPI_DATA_I = 8'h84;
    LINESTATE = 2'b10;
    tick();
    checks++;
    if (ULPI_NXT !== 1'b1 || ULPI_DIR !== 1'b0) begin
      errors++; $display("FAIL arb_link_wins nxt=%0b dir=%0b expected 1 0", ULPI_NXT, ULPI_DIR);
    end
    tick();
    ULPI_DATA_I = 8'h45;
    tick();
    ULPI_DATA_I = 8'h00;
    ULPI_STP = 1'b1;
    tick();
    ULPI_STP = 1'b0;
    checks++;
    if (REG_FUNC_CTRL !== 8'h45 || ULPI_DIR !== 1'b0) begin
      errors++; $display("FAIL arb_write_first func=%h dir=%0b expected 45 0", REG_FUNC_CTRL, ULPI_DIR);
    end
    tick();
    tick();
    checks++;
    if ({ULPI_DIR, ULPI_NXT, ULPI_DATA_O} !== {1'b1, 1'b0, 8'h02}) begin
      errors++; $display("FAIL arb_rxcmd dir=%0b nxt=%0b data=%h expected 1 0 02", ULPI_DIR, ULPI_NXT, ULPI_DATA_O);
    end
    tick();
    tick();
    checks++;
    if (ULPI_DIR !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL arb_done dir=%0b busy=%0b expected 0 0", ULPI_DIR, BUSY);
    end
  endtask

  task automatic test_reset_midop;
    wait_idle("midop");
    ULPI_DATA_I = 8'h96;
    tick();
    #3;
    NRST_A_USB = 1'b0;
    #1;
    checks++;
    if ({ULPI_DIR, ULPI_NXT, BUSY, REG_FUNC_CTRL} !== {1'b1, 1'b0, 1'b1, 8'h41}) begin
      errors++; $display("FAIL midop_reset dir=%0b nxt=%0b busy=%0b func=%h expected 1 0 1 41",
                         ULPI_DIR, ULPI_NXT, BUSY, REG_FUNC_CTRL);
    end
    ULPI_DATA_I = 8'h00;
    tick();
    NRST_A_USB = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_regs();
    test_write_abort();
    test_func_reset();
    test_transmit();
    test_tx_abort();
    test_rx_inject();
    test_rx_gap();
    test_arbitration();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ulpi_phy_model.md
Name: ulpi_phy_model

Overview:
- Synthesizable PHY-side ULPI responder, the opposite end of the link-side ULPI controller.
- Used for on-FPGA loopback and for bench stimulus of the link controller.
- Owns DIR/NXT, decodes TXCMDs, and implements a minimal ULPI register file.
- Captures transmitted packets and injects received packets and RXCMDs from a host-side stream interface.

Parameters:
- RESET_CYCLES, 16: DIR-high cycles after reset or after a FUNC_CTRL.Reset.
- VID, 16'h0424: value read back at addresses 0x00/0x01 (low/high).
- PID, 16'h0009: value read back at addresses 0x02/0x03 (low/high).

Ports:
- CLK_60M  in  1  ULPI clock.
- NRST_A_USB  in  1  Async active-low reset.
- ULPI_DATA_I  in  8  Bus value driven by the link.
- ULPI_DATA_O  out  8  Bus value driven by the PHY; valid when DIR=1 and not in a turnaround cycle.
- ULPI_DIR  out  1  Bus direction.
- ULPI_NXT  out  1  Throttle.
- ULPI_STP  in  1  Stop from the link.
- LINESTATE  in  2  Emulated line state.
- VBUS  in  2  Emulated VBUS state.
- RX_DATA  in  8  Byte to inject toward the link.
- RX_VALID  in  1  Injection byte available.
- RX_LAST  in  1  Marks the final byte of the injected packet.
- RX_READY  out  1  Injection byte consumed this cycle.
- TX_DATA  out  8  Captured transmit byte; byte 0 is the PID.
- TX_STRB  out  1  TX_DATA valid for one cycle.
- TX_END  out  1  One-cycle pulse when the link's STP ends a transmit.
- REG_FUNC_CTRL  out  8  Current FUNC_CTRL register value.
- BUSY  out  1  High in every state except IDLE.

Behaviour:
- Reset and clock: NRST_A_USB is asynchronous, active-low; the block is clocked on CLK_60M.
- Reset values:
  - DIR=1, NXT=0, DATA_O=0, all strobes 0, BUSY=1.
  - FUNC_CTRL=0x41, INTF_CTRL=0x00, OTG_CTRL=0x06, SCRATCH=0x00.
  - Last-reported RXCMD = 0x00.
- Register map; address+1 = set, address+2 = clear:
  - 0x04 FUNC_CTRL, 0x07 INTF_CTRL, 0x0A OTG_CTRL, 0x16 SCRATCH.
  - 0x00–0x03 are read-only ID registers.
  - Any other address reads 0x00; writes to it are ignored.
- RXCMD format: [1:0]=LINESTATE, [3:2]=VBUS, [5:4]=RxEvent (00 idle, 01 RxActive, 11 RxError), [7:6]=0.
- States:
  - PHY_RST: DIR=1 for RESET_CYCLES, then one cycle with DIR=0 as turnaround, then IDLE.
  - IDLE: DIR=0, NXT=0.
    - Priority 1: ULPI_DATA_I≠0 decodes as a TXCMD; the link wins arbitration.
    - Priority 2: RX_VALID → RX_TA.
    - Priority 3: {VBUS,LINESTATE} differs from the last reported value → CMD_TA.
  - TXCMD [7:6]=10 (register write):
    - WR_CMD: NXT=1 for one cycle.
    - WR_DATA: NXT=1; latch the data byte.
    - WR_STP: NXT=0; wait for STP=1, then commit the write and return to IDLE.
    - Write modes: write/set/clear apply to the selected register.
    - FUNC_CTRL bit5 (Reset) self-clears on commit and enters PHY_RST.
  - TXCMD [7:6]=11 (register read):
    - RD_CMD: NXT=1 for one cycle.
    - RD_TA: DIR=1, bus not driven.
    - RD_DATA: DIR=1, DATA_O = register value.
    - RD_END: DIR=0 turnaround, then IDLE.
  - TXCMD [7:6]=01 (transmit):
    - TX_PID: NXT=1; TX_DATA={4'b0, cmd[3:0]} with TX_STRB.
    - TX_BODY: NXT=1; each cycle with STP=0, TX_DATA=ULPI_DATA_I with TX_STRB.
    - STP=1 in TX_BODY: the byte on the bus is not captured; TX_END pulses; NXT=0; → IDLE.
  - TXCMD [7:6]=00 with a nonzero value: treated as NOOP; stay in IDLE.
  - Receive injection:
    - RX_TA: DIR=1 turnaround.
    - RX_CMD: NXT=0; DATA_O = RXCMD with RxEvent=01.
    - RX_BYTE: NXT=1; DATA_O=RX_DATA; RX_READY=1.
    - RX_VALID=0 mid-packet: RX_BYTE emits an RXCMD with NXT=0 instead of a data byte.
    - After RX_LAST is consumed: one RXCMD with RxEvent=00, then RX_END (DIR=0 turnaround) → IDLE.
  - CMD_TA / CMD_OUT: DIR=1 turnaround, then DIR=1 with NXT=0 and DATA_O = RXCMD (RxEvent=00); record the reported value; DIR=0 turnaround → IDLE.
- STP received while DIR=1 is ignored.
- STP received in WR_CMD, WR_DATA or TX_PID aborts the transaction with no commit and no TX_END → IDLE.
- Reset asserted mid-operation returns the block to PHY_RST immediately.

Optional Feature:
- Macro: ULPI_PHY_RX_ERR_EN.
- With the macro: an extra input RX_ERR (1 bit), sampled in RX_BYTE, makes the next cycle emit an RXCMD with RxEvent=11, then terminate the packet as for RX_LAST.
- Without the macro: the port is absent and RxEvent=11 is never generated.

Decomposition:
- Shared package ulpi_pkg holds:
  - TXCMD opcode constants.
  - Register addresses and reset values.
  - RxEvent encodings.
  - State encoding, 8-bit, matching the link controller's width.
- Sub-module ulpi_phy_regs: register file with write/set/clear decode, ID read-only values, and the FUNC_CTRL reset self-clear.

Test Plan:
- Release reset → DIR high for 16 cycles, low thereafter; reading address 0x04 returns 0x41.
- Write TXCMD 0x96 with data 0x5A, then STP → SCRATCH=0x5A; TXCMD 0x97 with data 0x0F → SCRATCH=0x5F; a read of 0x16 returns 0x5F on DATA_O in RD_DATA.
- Write 0x84 with data 0x61 → DIR=1 for 16 cycles; REG_FUNC_CTRL=0x41 afterwards (bit5 cleared).
- Link sends 0x43, bytes 0xAA, 0xBB, then STP → TX_STRB pulses TX_DATA 0x03, 0xAA, 0xBB; TX_END pulses once.
- Inject bytes 0x11, 0x22 (LAST), LINESTATE=01 → bus shows RXCMD 0x11, then 0x11 and 0x22 with NXT=1, then RXCMD 0x01, then DIR=0.
- LINESTATE changes 01→10 while the link issues TXCMD 0x84 in the same cycle → the register write completes first, then RXCMD 0x02 is sent.
